// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage of the single-cycle MIPS core.
// Holds the PC, fetches one word per instruction over a req/ack handshake,
// presents instr/opcode/pc to decode and computes the next PC on retire.
// Optional feature: define FETCH_JUMP_EN to enable pseudo-direct jumps
// (opcode 6'b000010); without it no jump logic is built.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        retire,
    input  logic        branch_eq,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic        valid_reg, valid_next;

    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic        take_branch;
    logic [31:0] next_pc;

    // Outputs come straight from the held registers; opcode is a plain slice.
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign opcode      = instr_reg[31:26];
    assign instr_valid = valid_reg;

    // Next-PC candidates, all modulo 2^32.
    assign pc_plus4      = pc_reg + 32'd4;
    assign branch_offset = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_offset;
    assign take_branch   = branch_eq && alu_zero;

`ifdef FETCH_JUMP_EN
    logic        is_jump;
    logic [31:0] jump_target;

    assign is_jump     = (instr_reg[31:26] == 6'b000010);
    assign jump_target = {pc_plus4[31:28], instr_reg[25:0], 2'b00};

    // Jump outranks a simultaneous taken branch.
    always_comb begin
        next_pc = pc_plus4;
        if (is_jump) begin
            next_pc = jump_target;
        end else if (take_branch) begin
            next_pc = branch_target;
        end
    end
`else
    // Sequential flow unless the branch condition holds.
    always_comb begin
        next_pc = pc_plus4;
        if (take_branch) begin
            next_pc = branch_target;
        end
    end
`endif

    // State register; reset forces IDLE regardless of any handshake in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and request: request only while in FETCH.
    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (retire) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath next values: capture on ack in FETCH, advance PC on retire in HOLD.
    always_comb begin
        pc_next    = pc_reg;
        instr_next = instr_reg;
        valid_next = valid_reg;
        if (state_reg == FETCH && imem_ack) begin
            instr_next = imem_rdata;
            valid_next = 1'b1;
        end else if (state_reg == HOLD && retire) begin
            pc_next    = next_pc;
            valid_next = 1'b0;
        end
    end

    // Datapath registers; acked data in a reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            instr_reg <= 32'h0000_0000;
            valid_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
        end
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-cycle MIPS core, sitting directly upstream of the main control decoder. It holds the PC and fetches one 32-bit word from instruction memory over a req/ack handshake. It presents the instruction and its opcode field to decode and the datapath, then computes the next PC on retire (sequential, beq-taken, or optional jump).

## Interface
- RESET_PC, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held high until acked.
- imem_addr  out  32  fetch address; stable while imem_req high.
- imem_ack  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  32  fetched word.
- instr  out  32  held instruction.
- opcode  out  6  instr[31:26], to control decoder.
- instr_valid  out  1  instr/opcode/pc valid for decode.
- pc  out  32  address of held instruction.
- retire  in  1  datapath has completed the held instruction.
- branch_eq  in  1  from control decoder, sampled with retire.
- alu_zero  in  1  ALU zero flag, sampled with retire.

## Operation
- FSM states: IDLE, FETCH, HOLD.
- IDLE: entered on reset; goes to FETCH on the next clock.
- FETCH: imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, instr_valid<=1, go HOLD.
  - Without ack: stay in FETCH; address held; unbounded wait.
- HOLD: imem_req=0, instr_valid=1.
  - On retire: load pc<=next_pc, instr_valid<=0, go FETCH.
  - Without retire: hold all outputs.
- next_pc:
  - Branch taken (branch_eq && alu_zero): pc+4 + (sign_extend(instr[15:0]) << 2).
  - Jump (FETCH_JUMP_EN only): opcode 6'b000010 gives {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Otherwise: pc+4.
- All arithmetic is 32-bit modulo 2^32. pc=32'hFFFF_FFFC with sequential flow wraps to 32'h0000_0000. Negative offsets wrap the same way.
- Ignored inputs:
  - imem_ack outside FETCH.
  - retire outside HOLD.
  - branch_eq and alu_zero when retire is not accepted.
- Reset values: state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, instr=0, opcode=0, instr_valid=0.
- Reset mid-operation: reset wins over every other event in the same cycle, including an in-flight req/ack or a retire. Any acked data is discarded and the next request goes to RESET_PC.

## Timing
- Fetch latency: when ack arrives in the first FETCH cycle, instr_valid rises the following cycle. Every cycle of ack delay adds one cycle.
- Retire in cycle N: pc updated and imem_req high in cycle N+1.
- Minimum instruction period: 2 cycles (FETCH with immediate ack, then HOLD with immediate retire).
- After reset deasserts: first imem_req asserts 2 cycles later (IDLE, then FETCH).
- opcode is a wire of instr: same-cycle valid and no extra register.
- The control decoder sees opcode stable for the whole of HOLD.

## Configuration
- FETCH_JUMP_EN defined: opcode 6'b000010 (j) retires to the pseudo-direct jump target. Jump takes priority over a simultaneous branch_eq.
- Not defined: opcode 6'b000010 retires to pc+4 (or the branch target if branch_eq && alu_zero). No jump logic is synthesized.

## Test plan
- Reset/first fetch: hold reset 3 cycles with RESET_PC=0.
  - Required: during reset imem_req=0 and instr_valid=0. After release, imem_req=1 with imem_addr=0 two cycles later.
  - Then ack with rdata 32'h8C01_0004 (lw). Required: instr_valid=1 and opcode=6'b100011 next cycle.
- Stalled memory: hold ack low 5 cycles after request.
  - Required: imem_req and imem_addr stay constant, and instr_valid stays 0.
  - On ack, instr_valid=1 exactly one cycle later.
- Branch taken: pc=32'h0000_0010, instr=32'h1022_FFFC (beq, offset -4), retire with branch_eq=1 and alu_zero=1.
  - Required: next imem_addr=32'h0000_0004.
  - Repeat with alu_zero=0. Required: 32'h0000_0014.
- Wrap-around: pc=32'hFFFF_FFFC, R-format instruction, retire with branch_eq=0.
  - Required: next imem_addr=32'h0000_0000.
- Reset mid-fetch: assert reset in the same cycle as imem_ack=1 with pc=32'h40.
  - Required: instr_valid stays 0, instr=0, and the next request is to RESET_PC.
- Jump (FETCH_JUMP_EN): pc=32'h1000_0000, instr=32'h0800_0040, retire.
  - Required with the macro: next addr=32'h1000_0100.
  - Required without the macro: next addr=32'h1000_0004.
